// File: rtl/alu_md_controller.sv
// alu_md_controller: EX-stage ALU control decoder with an embedded iterative
// RV32M multiply/divide engine.
//  - Operation is decoded combinationally from ALUOp/Funct7/Funct3.
//  - R-type Funct7=0000001 instructions run in a shift-add multiplier or a
//    restoring divider (one bit per cycle), and the pipeline stalls meanwhile.
//  - Optional macro MD_EARLY_OUT_EN: divide by zero, multiply by zero and the
//    signed division overflow go straight from IDLE to DONE (1-cycle result).
//    Without the macro every md op takes exactly WIDTH+1 cycles.
module alu_md_controller #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             flush,
  input  logic             is_rtype,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       Operation,
  output logic             md_sel,
  output logic [WIDTH-1:0] md_result,
  output logic             md_done,
  output logic             stall
);

  // ALU operation codes
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BR   = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MD  = 7'b0000001;

  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]     ZERO_W1  = {(WIDTH+1){1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

  // Sign-correct the raw engine result and pick the field Funct3 asks for.
  // acc holds the product for multiplies, {remainder, quotient} for divides.
  function automatic logic [WIDTH-1:0] md_finish(
    input logic [2:0]         f3,
    input logic [2*WIDTH-1:0] acc,
    input logic               neg_res,
    input logic               neg_rem,
    input logic               div_zero
  );
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    prod = neg_res ? (~acc + ONE_2W) : acc;
    if (div_zero) begin
      quo = ONES_W;
    end else begin
      quo = neg_res ? (~acc[WIDTH-1:0] + ONE_W) : acc[WIDTH-1:0];
    end
    rem = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + ONE_W) : acc[2*WIDTH-1:WIDTH];
    case (f3)
      3'b000:                 md_finish = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: md_finish = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         md_finish = quo;
      3'b110, 3'b111:         md_finish = rem;
      default:                md_finish = ZERO_W;
    endcase
  endfunction

  md_state_e          state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   md_result_q, md_result_d;
  logic               md_done_q, md_done_d;

  logic               md_op;
  logic [3:0]         alu_op;
  logic               stall_c;
  logic               is_div;
  logic               a_signed, b_signed;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               b_zero;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign md_op = valid & is_rtype & (ALUOp == 2'b10) & (Funct7 == F7_MD);

  // Single-cycle ALU decode; md ops and unknown encodings fall back to ADD.
  always_comb begin
    alu_op = OP_ADD;
    if (md_op) begin
      alu_op = OP_ADD;
    end else begin
      case (ALUOp)
        2'b00: alu_op = OP_ADD;
        2'b01: alu_op = OP_BR;
        2'b10: begin
          case (Funct3)
            3'b000: alu_op = (is_rtype && (Funct7 == F7_ALT)) ? OP_SUB : OP_ADD;
            3'b001: alu_op = OP_SLL;
            3'b010: alu_op = OP_SLT;
            3'b011: alu_op = OP_SLTU;
            3'b100: alu_op = OP_XOR;
            3'b101: alu_op = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            3'b110: alu_op = OP_OR;
            3'b111: alu_op = OP_AND;
            default: alu_op = OP_ADD;
          endcase
        end
        2'b11: alu_op = OP_ADD;
        default: alu_op = OP_ADD;
      endcase
    end
  end

  // Operand signedness per Funct3 and the magnitudes the engine works on.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (Funct3)
      3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:         begin a_signed = 1'b1; b_signed = 1'b0; end
      3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:        begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
    is_div = Funct3[2];
    neg_a  = a_signed & op_a[WIDTH-1];
    neg_b  = b_signed & op_b[WIDTH-1];
    mag_a  = neg_a ? (~op_a + ONE_W) : op_a;
    mag_b  = neg_b ? (~op_b + ONE_W) : op_b;
    b_zero = (op_b == ZERO_W);
  end

  // One engine step: shift-add multiply or restoring divide on acc_q.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : ZERO_W1);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

`ifdef MD_EARLY_OUT_EN
  logic             a_zero;
  logic             div_ovf;
  logic             early_hit;
  logic [WIDTH-1:0] early_res;

  // Recognise operand patterns whose result is known without iterating.
  always_comb begin
    a_zero    = (op_a == ZERO_W);
    div_ovf   = is_div & a_signed & (op_a == MIN_W) & (op_b == ONES_W);
    early_hit = 1'b0;
    early_res = ZERO_W;
    if (is_div) begin
      if (b_zero) begin
        early_hit = 1'b1;
        early_res = Funct3[1] ? op_a : ONES_W;
      end else if (div_ovf) begin
        early_hit = 1'b1;
        early_res = Funct3[1] ? ZERO_W : MIN_W;
      end else begin
        early_hit = 1'b0;
        early_res = ZERO_W;
      end
    end else begin
      if (a_zero || b_zero) begin
        early_hit = 1'b1;
        early_res = ZERO_W;
      end else begin
        early_hit = 1'b0;
        early_res = ZERO_W;
      end
    end
  end
`endif

  // md FSM next-state, datapath updates and the stall request.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    f3_d        = f3_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    cnt_d       = cnt_q;
    md_result_d = md_result_q;
    md_done_d   = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = md_op;
        if (md_op && !flush) begin
          f3_d       = Funct3;
          neg_res_d  = neg_a ^ neg_b;
          neg_rem_d  = neg_a;
          div_zero_d = is_div & b_zero;
          cnt_d      = CNT_ZERO;
          if (is_div) begin
            opnd_d = mag_b;
            acc_d  = {ZERO_W, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {ZERO_W, mag_b};
          end
`ifdef MD_EARLY_OUT_EN
          if (early_hit) begin
            state_d     = S_DONE;
            md_result_d = early_res;
            md_done_d   = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
`else
          state_d = S_BUSY;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          stall_c = 1'b0;
        end else begin
          stall_c = 1'b1;
          acc_d   = f3_q[2] ? div_next : mul_next;
          if (cnt_q == CNT_LAST) begin
            state_d     = S_DONE;
            cnt_d       = CNT_ZERO;
            md_result_d = md_finish(f3_q, acc_d, neg_res_q, neg_rem_q, div_zero_q);
            md_done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      // The pipeline advances in DONE, so the held instruction is not restarted.
      S_DONE: begin
        state_d = S_IDLE;
        stall_c = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= {(2*WIDTH){1'b0}};
      opnd_q      <= ZERO_W;
      f3_q        <= 3'b000;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      cnt_q       <= CNT_ZERO;
      md_result_q <= ZERO_W;
      md_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      f3_q        <= f3_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      div_zero_q  <= div_zero_d;
      cnt_q       <= cnt_d;
      md_result_q <= md_result_d;
      md_done_q   <= md_done_d;
    end
  end

  assign Operation = alu_op;
  assign md_sel    = md_op;
  assign md_result = md_result_q;
  // A flush in the DONE cycle kills the completion pulse.
  assign md_done   = md_done_q & ~flush;
  assign stall     = stall_c;

endmodule

// File: tb/tb_alu_md_controller.sv
// Self-checking bench for alu_md_controller (WIDTH=32): decode sweep, directed
// and randomized mul/div ops against a plain-arithmetic reference, flush and
// mid-operation reset. Latency expectations follow MD_EARLY_OUT_EN if defined.
module tb_alu_md_controller;

  localparam int W = 32;
`ifdef MD_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  // ADD SLL SLT SLTU XOR SRL OR AND, indexed by Funct3
  localparam logic [3:0] BASE_OPS [8] = '{4'h2, 4'h4, 4'hC, 4'hD, 4'h3, 4'h5, 4'h1, 4'h0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         valid = 1'b0;
  logic         flush = 1'b0;
  logic         is_rtype = 1'b0;
  logic [1:0]   ALUOp = 2'b00;
  logic [6:0]   Funct7 = 7'h00;
  logic [2:0]   Funct3 = 3'b000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   Operation;
  logic         md_sel;
  logic [W-1:0] md_result;
  logic         md_done;
  logic         stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_md_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush), .is_rtype(is_rtype),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .op_a(op_a), .op_b(op_b),
    .Operation(Operation), .md_sel(md_sel), .md_result(md_result),
    .md_done(md_done), .stall(stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_operation(input logic vld, input logic rt,
      input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3);
    if (vld && rt && aop == 2'b10 && f7 == 7'h01) return 4'h2;
    if (aop == 2'b01) return 4'h8;
    if (aop != 2'b10) return 4'h2;
    if (f3 == 3'd0 && rt && f7 == 7'h20) return 4'h6;
    if (f3 == 3'd5 && f7 == 7'h20) return 4'h7;
    return BASE_OPS[f3];
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'd0: begin r = ua * ub; return r[31:0]; end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin if (b == 32'h0) return 32'hFFFFFFFF; r = sa / sb; return r[31:0]; end
      3'd5: begin if (b == 32'h0) return 32'hFFFFFFFF; r = ua / ub; return r[31:0]; end
      3'd6: begin if (b == 32'h0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 32'h0) return a; r = ua % ub; return r[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit early;
    if (f3[2]) early = (b == 32'h0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    else       early = (a == 32'h0) || (b == 32'h0);
    if (EARLY_EN && early) return 1;
    return W + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_decode(input logic vld, input logic rt, input logic [1:0] aop,
      input logic [6:0] f7, input logic [2:0] f3);
    @(negedge clk);
    flush = 1'b1; valid = vld; is_rtype = rt; ALUOp = aop; Funct7 = f7; Funct3 = f3;
    #1;
  endtask

  // Issue one md op and follow it to completion.
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] exp_res, input bit scramble);
    int exp_lat, cyc, stall_cnt;
    bit seen;
    exp_lat = ref_latency(f3, a, b);
    @(negedge clk);
    flush = 1'b0; valid = 1'b1; is_rtype = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01;
    Funct3 = f3; op_a = a; op_b = b;
    #1;
    check_eq({tag, " md_sel"}, 64'(md_sel), 64'd1);
    stall_cnt = stall ? 1 : 0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (md_done) begin
        seen = 1'b1;
      end else begin
        if (stall) stall_cnt++;
        if (scramble) begin op_a = $urandom; op_b = $urandom; end
      end
    end
    check_eq({tag, " done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, " result"}, 64'(md_result), 64'(exp_res));
    check_eq({tag, " stall_done"}, 64'(stall), 64'd0);
    check_eq({tag, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
    valid = 1'b0;
    @(negedge clk);
    check_eq({tag, " done_pulse"}, 64'(md_done), 64'd0);
    check_eq({tag, " result_hold"}, 64'(md_result), 64'(exp_res));
  endtask

  initial begin
    int cnt;
    logic [2:0] f3;
    logic [31:0] a, b;
    logic [6:0] f7;
    logic vld, rt;
    logic [1:0] aop;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst md_result", 64'(md_result), 64'd0);
    check_eq("rst md_done", 64'(md_done), 64'd0);
    check_eq("rst stall", 64'(stall), 64'd0);
    check_eq("rst md_sel", 64'(md_sel), 64'd0);
    rst_n = 1'b1;

    // Directed decode
    drive_decode(1'b1, 1'b1, 2'b10, 7'h20, 3'b000); check_eq("dec SUB", 64'(Operation), 64'h6);
    drive_decode(1'b1, 1'b0, 2'b10, 7'h20, 3'b000); check_eq("dec ADDI", 64'(Operation), 64'h2);
    drive_decode(1'b1, 1'b1, 2'b10, 7'h00, 3'b011); check_eq("dec SLTU", 64'(Operation), 64'hD);
    drive_decode(1'b1, 1'b1, 2'b10, 7'h20, 3'b101); check_eq("dec SRA", 64'(Operation), 64'h7);
    drive_decode(1'b1, 1'b0, 2'b10, 7'h20, 3'b101); check_eq("dec SRAI", 64'(Operation), 64'h7);
    drive_decode(1'b1, 1'b1, 2'b01, 7'h00, 3'b000); check_eq("dec BR", 64'(Operation), 64'h8);
    drive_decode(1'b1, 1'b1, 2'b10, 7'h01, 3'b110);
    check_eq("dec MD op", 64'(Operation), 64'h2);
    check_eq("dec MD sel", 64'(md_sel), 64'd1);

    // Random decode, flushed so no md op can start
    for (int i = 0; i < 60; i++) begin
      vld = 1'($urandom); rt = 1'($urandom); aop = 2'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      drive_decode(vld, rt, aop, f7, f3);
      check_eq($sformatf("dec rnd%0d op", i), 64'(Operation), 64'(ref_operation(vld, rt, aop, f7, f3)));
      check_eq($sformatf("dec rnd%0d sel", i), 64'(md_sel),
               64'(vld && rt && aop == 2'b10 && f7 == 7'h01));
    end
    check_eq("flushed no start", 64'(md_done), 64'd0);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;

    // Directed md ops
    run_md("MULH -1*2", 3'b001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 1'b0);
    run_md("MUL -1*2", 3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0);
    run_md("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_md("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_md("DIVU 7/0", 3'b101, 32'h7, 32'h0, 32'hFFFFFFFF, 1'b0);
    run_md("REMU 7/0", 3'b111, 32'h7, 32'h0, 32'h7, 1'b0);
    run_md("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0);
    run_md("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0);
    run_md("DIV -5/0", 3'b100, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, 1'b0);
    run_md("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

    // Flush in BUSY cycle 10
    @(negedge clk);
    valid = 1'b1; is_rtype = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'b100;
    op_a = 32'd100; op_b = 32'd7;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush = 1'b1;
    #1;
    check_eq("flush stall", 64'(stall), 64'd0);
    check_eq("flush done", 64'(md_done), 64'd0);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_done) cnt++;
    end
    check_eq("flush no done", 64'(cnt), 64'd0);
    run_md("after flush", 3'b100, 32'd100, 32'd7, 32'd14, 1'b0);

    // Reset in the middle of BUSY
    @(negedge clk);
    valid = 1'b1; is_rtype = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'b000;
    op_a = 32'h1234; op_b = 32'h5678;
    repeat (5) @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst result", 64'(md_result), 64'd0);
    check_eq("midrst done", 64'(md_done), 64'd0);
    check_eq("midrst stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_done || stall) cnt++;
    end
    check_eq("midrst idle", 64'(cnt), 64'd0);
    run_md("after rst", 3'b000, 32'h1234, 32'h5678, 32'h06260060, 1'b0);

    // Randomized md ops with operands scrambled while busy
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      run_md($sformatf("rnd%0d f3=%0d", i, f3), f3, a, b, ref_md(f3, a, b), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
